div16_seq: RTL
==============

Name: div16_seq

Overview:
- Sequencer for the shared 16-bit add/subtract datapath.
- Performs unsigned 16-bit restoring division, one iteration per clock, 16 iterations.
- Owns the adder's operand, mode and enable lines during a division; the datapath itself sits outside this block.
- Result and flags are registered and held until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported.
- CNT_W, 5, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  16  numerator, captured on accepted start.
- divisor  input  16  denominator, captured on accepted start.
- ready  output  1  high in IDLE and DONE; start is accepted here.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse when quotient/remainder are valid.
- quotient  output  16  result, held until next accepted start.
- remainder  output  16  result, held until next accepted start.
- div_zero  output  1  set with done when divisor was 0.
- add_en  output  1  high in CALC; the outer mux grants the adder to this block.
- add_a  output  16  adder operand A.
- add_b  output  16  adder operand B.
- add_sub  output  1  adder carry-in/subtract select; 1 in CALC.
- add_sum  input  16  adder result.
- add_cout  input  1  adder carry-out; 1 means A>=B when subtracting.

Behaviour:
- States: IDLE, CALC, DONE. Reset drives IDLE from any state, including mid-CALC, with no partial result exposed.
- Reset values: ready=1, busy=0, done=0, quotient=0, remainder=0, div_zero=0, add_en=0, add_a=0, add_b=0, add_sub=0. Internal R=0, Q=0, D=0, cnt=0.
- Accepted start (ready && start): captures Q=dividend, D=divisor, R=0, cnt=0. Clears div_zero.
  - If divisor==0: go to DONE next cycle; quotient=16'hFFFF, remainder=dividend, div_zero=1.
  - Otherwise: go to CALC.
- start is ignored while busy=1. Operands need not be held after acceptance.
- CALC datapath drive, combinational from registers: add_a={R[14:0],Q[15]}, add_b=D, add_sub=1, add_en=1. Outside CALC, add_a, add_b and add_sub are 0.
- CALC iteration, each cycle:
  - take = add_cout | R[15]. R[15]=1 means the shifted partial remainder is at least 2^16 and therefore exceeds D.
  - If take: R<=add_sum. Else: R<={R[14:0],Q[15]}.
  - Q<={Q[14:0],take}; cnt<=cnt+1.
  - When cnt==15 (16th iteration): load quotient and remainder from the next-state Q and R, then go to DONE.
- DONE: done=1 for exactly one cycle, ready=1. With start=1 the next operation is accepted (back-to-back); otherwise go to IDLE.
- Latency: start accepted at edge 0 → done high during cycle 17 (16 CALC cycles + DONE). Divide-by-zero: done high in cycle 1.
- Throughput: one division per 17 cycles with back-to-back starts.
- quotient, remainder and div_zero change only when entering DONE and are stable otherwise.
- The adder is treated as purely combinational: add_sum and add_cout are valid in the same cycle as add_a and add_b.

Test Plan:
- dividend=100, divisor=7, start pulse → busy 16 cycles, done in cycle 17, quotient=14, remainder=2, div_zero=0.
- 0xFFFF/0x0001 → quotient=0xFFFF, remainder=0. Also 0x0005/0x0009 → quotient=0, remainder=5.
- 0xFFFF/0x8001 (exercises the R[15] take path) → quotient=1, remainder=0x7FFE. Also 0xFFFE/0xFFFF → quotient=0, remainder=0xFFFE.
- 0x1234/0 → done in cycle 1, quotient=0xFFFF, remainder=0x1234, div_zero=1, add_en never high.
- start re-asserted mid-CALC with new operands → ignored, first result unchanged. Then start held high in DONE with 50/5 → next result quotient=10, remainder=0 after 17 more cycles.
- reset asserted at CALC cycle 8 → next cycle IDLE, ready=1, busy=0, all outputs 0. A subsequent 1000/33 → quotient=30, remainder=10.

Source files
------------

// File: rtl/div16_seq.sv
// div16_seq: sequencer that runs unsigned 16-bit restoring division on an
// external shared add/subtract datapath, one quotient bit per clock.
// A start accepted while ready captures the operands; 16 CALC cycles later
// the result is loaded and done pulses for one cycle in DONE.
// Divide-by-zero skips CALC and reports quotient=all-ones,
// remainder=dividend and div_zero=1.

module div16_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value during the 16th (final) iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] r_q;      // partial remainder
  logic [WIDTH-1:0] q_q;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_q;      // captured divisor
  logic [CNT_W-1:0] cnt;      // iteration index within CALC

  logic [WIDTH-1:0] shifted;  // low bits of (R << 1) | next dividend bit
  logic             take;     // this iteration produces a quotient 1
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             in_calc;

  assign in_calc = (state == CALC);
  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  // Adder drive and next-iteration values, decoded from registered state.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch can be inferred.
    add_en  = 1'b0;
    add_sub = 1'b0;
    add_a   = '0;
    add_b   = '0;
    if (in_calc) begin
      add_en  = 1'b1;
      add_sub = 1'b1;
      add_a   = shifted;
      add_b   = d_q;
    end
    // R[15] set means the shifted remainder is >= 2^16 and so exceeds D, even
    // though the 16-bit subtract reports a borrow. The true difference is
    // still below D, so the 16-bit add_sum holds it exactly.
    take   = add_cout | r_q[WIDTH-1];
    r_next = take ? add_sum : shifted;
    q_next = {q_q[WIDTH-2:0], take};
  end

  // Control FSM, iteration registers and registered result/status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    if (reset) begin
      // NOTE: every register here is a flop, not a memory array, so all of
      // them are cleared; a reset mid-CALC therefore exposes no partial result.
      state     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // ready is high in both states, so start alone means acceptance.
          if (start) begin
            q_q      <= dividend;
            d_q      <= divisor;
            r_q      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              ready     <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            quotient  <= q_next;
            remainder <= r_next;
            state     <= DONE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
